data_ram_responder: RTL and testbench



---
 rtl/data_ram_responder_pkg.sv | 25 ++
 rtl/mmio_timer.sv | 80 ++++++++
 rtl/data_ram_responder.sv | 64 ++++++
 tb/tb_data_ram_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/data_ram_responder_pkg.sv
// Shared constants and helpers for the data-memory responder.
// MMIO offsets, window base and the byte-lane merge used by every write path.
package data_ram_responder_pkg;

    localparam logic [31:0] MMIO_BASE_DEF = 32'hBFAF_0000;

    localparam logic [15:0] LED_OFF    = 16'h0000;
    localparam logic [15:0] COUNT_OFF  = 16'h0004;
    localparam logic [15:0] CMP_OFF    = 16'h0008;
    localparam logic [15:0] STATUS_OFF = 16'h000C;

    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  sel
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// MMIO register block: LED, free-running COUNT, CMP/pending timer.
// Decodes the window offset and flags accesses to unmapped offsets.
module mmio_timer
    import data_ram_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [15:0] off,
    input  logic [3:0]  sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [15:0] led,
    output logic        irq,
    output logic        err
);

    logic [31:0] led_r;
    logic [31:0] count;
    logic [31:0] cmp;
    logic        pending;

    logic hit_led;
    logic hit_count;
    logic hit_cmp;
    logic hit_status;
    logic mapped;
    logic set_pend;
    logic clr_pend;

    always_comb begin
        hit_led    = (off == LED_OFF);
        hit_count  = (off == COUNT_OFF);
        hit_cmp    = (off == CMP_OFF);
        hit_status = (off == STATUS_OFF);
        mapped     = hit_led | hit_count | hit_cmp | hit_status;
        set_pend   = (count == cmp) && (cmp != 32'h0);
        clr_pend   = ce & we & hit_status & sel[0] & wdata[0];
    end

    always_comb begin
        rdata = 32'h0;
        if (ce) begin
            unique case (1'b1)
                hit_led:    rdata = led_r;
                hit_count:  rdata = count;
                hit_cmp:    rdata = cmp;
                hit_status: rdata = {31'h0, pending};
                default:    rdata = 32'h0;
            endcase
        end
    end

    // led_r upper lanes are never enabled, so they stay zero and read back as 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r   <= 32'h0;
            count   <= 32'h0;
            cmp     <= 32'h0;
            pending <= 1'b0;
            err     <= 1'b0;
        end else begin
            count <= count + 32'h1;
            err   <= ce & ~mapped;
            if (ce && we && hit_led)
                led_r <= lane_merge(led_r, wdata, {2'b00, sel[1:0]});
            if (ce && we && hit_cmp)
                cmp <= lane_merge(cmp, wdata, sel);
            if (set_pend)
                pending <= 1'b1;
            else if (clr_pend)
                pending <= 1'b0;
        end
    end

    assign led = led_r[15:0];
    assign irq = pending;

endmodule

// File: rtl/data_ram_responder.sv
// Data-memory bus responder: word RAM with byte lanes plus MMIO window.
// Loads are combinational; stores and register updates happen on the clock.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [15:0] led_o,
    output logic        timer_irq_o,
    output logic        err_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  mmio_hit;
    logic                  mmio_ce;
    logic                  ram_we;
    logic [31:0]           ram_rdata;
    logic [31:0]           mmio_rdata;

    assign idx      = addr_i[ADDR_WIDTH+1:2];
    assign mmio_hit = (addr_i[31:16] == MMIO_BASE[31:16]);
    assign mmio_ce  = ce_i & mmio_hit;
    assign ram_we   = ce_i & we_i & ~mmio_hit;
    assign ram_rdata = mem[idx];

    mmio_timer u_mmio (
        .clk   (clk),
        .rst   (rst),
        .ce    (mmio_ce),
        .we    (we_i),
        .off   (addr_i[15:0]),
        .sel   (sel_i),
        .wdata (data_i),
        .rdata (mmio_rdata),
        .led   (led_o),
        .irq   (timer_irq_o),
        .err   (err_o)
    );

    // rst only gates the write; the array itself has no reset value
    always_ff @(posedge clk or posedge rst) begin
        if (!rst && ram_we)
            mem[idx] <= lane_merge(mem[idx], data_i, sel_i);
    end

    always_comb begin
        data_o = 32'h0;
        if (!rst && ce_i)
            data_o = mmio_hit ? mmio_rdata : ram_rdata;
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_data_ram_responder;

    logic        clk;
    logic        rst;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [15:0] led_o;
    logic        timer_irq_o;
    logic        err_o;

    int nvec;
    int nbad;
    int cyc;

    localparam logic [31:0] MB     = 32'hBFAF_0000;
    localparam logic [31:0] A_LED  = MB + 32'h0;
    localparam logic [31:0] A_CNT  = MB + 32'h4;
    localparam logic [31:0] A_CMP  = MB + 32'h8;
    localparam logic [31:0] A_STAT = MB + 32'hC;
    localparam logic [31:0] A_BAD  = MB + 32'h10;

    data_ram_responder dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .sel_i       (sel_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .led_o       (led_o),
        .timer_irq_o (timer_irq_o),
        .err_o       (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input logic ce, input logic we,
                         input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
        ce_i   = ce;
        we_i   = we;
        addr_i = a;
        sel_i  = s;
        data_i = d;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic ld(input logic [31:0] a);
        drive(1'b1, 1'b0, a, 4'hF, 32'h0);
    endtask

    task automatic st(input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d);
        drive(1'b1, 1'b1, a, s, d);
    endtask

    initial begin
        nvec = 0;
        nbad = 0;
        cyc  = 0;
        rst  = 1'b1;
        ld(32'h0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_led", {16'h0, led_o}, 32'h0);
        chk("rst_irq", {31'h0, timer_irq_o}, 32'h0);
        chk("rst_err", {31'h0, err_o}, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        ld(A_CNT);
        chk("count_c0", data_o, 32'd0);
        tick(); ld(A_CNT);
        chk("count_c1", data_o, 32'd1);
        tick(); st(A_CMP, 4'hF, 32'd10);
        tick(); ld(A_CMP);
        chk("cmp_rd", data_o, 32'd10);
        tick(); idle();
        while (cyc < 10) begin
            tick(); idle();
        end
        chk("irq_c10", {31'h0, timer_irq_o}, 32'h0);
        tick();
        chk("irq_c11", {31'h0, timer_irq_o}, 32'h1);
        ld(A_STAT);
        chk("stat_rd", data_o, 32'h1);
        st(A_STAT, 4'h1, 32'h1);
        tick(); ld(A_STAT);
        chk("irq_clr", {31'h0, timer_irq_o}, 32'h0);
        chk("stat_clr", data_o, 32'h0);
        st(A_CMP, 4'hF, 32'd14);
        tick(); idle();
        tick(); idle();
        tick(); st(A_CMP, 4'hF, 32'd16);
        chk("irq_c15", {31'h0, timer_irq_o}, 32'h1);
        tick(); st(A_STAT, 4'h1, 32'h1);
        chk("cnt_match", {31'h0, timer_irq_o}, 32'h1);
        tick(); st(A_STAT, 4'h1, 32'h1);
        chk("set_wins", {31'h0, timer_irq_o}, 32'h1);
        tick(); idle();
        chk("irq_clr2", {31'h0, timer_irq_o}, 32'h0);

        tick(); st(32'h100, 4'hF, 32'hAABBCCDD);
        tick(); st(32'h100, 4'h1, 32'h00000011);
        tick(); ld(32'h100);
        chk("byte_st", data_o, 32'hAABBCC11);
        tick(); st(32'h4000, 4'hF, 32'h12345678);
        tick(); ld(32'h0);
        chk("alias", data_o, 32'h12345678);
        tick(); st(32'h20, 4'hF, 32'h9);
        tick(); st(32'h20, 4'hF, 32'h5);
        chk("rw_old", data_o, 32'h9);
        tick(); ld(32'h20);
        chk("rw_new", data_o, 32'h5);
        tick(); st(32'h20, 4'h0, 32'hFFFFFFFF);
        tick(); ld(32'h20);
        chk("sel0", data_o, 32'h5);
        tick(); idle();
        chk("idle_data", data_o, 32'h0);

        tick(); st(A_LED, 4'hF, 32'h1234BEEF);
        tick(); ld(A_LED);
        chk("led_o", {16'h0, led_o}, 32'h0000BEEF);
        chk("led_rd", data_o, 32'h0000BEEF);
        st(A_LED, 4'h2, 32'h00005500);
        tick(); idle();
        chk("led_lane", {16'h0, led_o}, 32'h000055EF);

        tick(); ld(A_BAD);
        chk("bad_rd", data_o, 32'h0);
        chk("err_pre", {31'h0, err_o}, 32'h0);
        tick(); idle();
        chk("err_hi", {31'h0, err_o}, 32'h1);
        tick(); idle();
        chk("err_lo", {31'h0, err_o}, 32'h0);
        st(A_CNT, 4'hF, 32'hFFFFFFFF);
        tick(); ld(A_CNT);
        chk("cnt_ro", data_o, cyc);

        tick();
        rst = 1'b1;
        st(A_LED, 4'hF, 32'h0000BEEF);
        chk("rst_led_now", {16'h0, led_o}, 32'h0);
        chk("rst_data_now", data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        ld(A_CNT);
        chk("rst_cnt", data_o, 32'h0);
        chk("rst_led_after", {16'h0, led_o}, 32'h0);
        tick(); idle();
        chk("rst_led_c1", {16'h0, led_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
